// File: rtl/adc_peak_reporter.sv
// Per-channel peak hold with a command-driven report packetiser feeding a UART TX.
// Each report packet is: header ('A'+ch), MSB-first zero-padded data bytes, XOR checksum.

module adc_peak_lane #(
  parameter int SAMPLE_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic                clear,
  output logic [SAMPLE_W-1:0] peak
);
  // A coincident sample survives a clear so no ADC reading is lost.
  always_ff @(posedge clk) begin
    if (reset)
      peak <= '0;
    else if (clear)
      peak <= sample_valid ? sample : '0;
    else if (sample_valid && (sample > peak))
      peak <= sample;
  end
endmodule

module adc_peak_reporter #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  input  logic [NUM_CH-1:0]          sample_valid,
  input  logic [7:0]                 cmd_byte,
  input  logic                       cmd_valid,
  output logic [7:0]                 tx_byte,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       cmd_dropped,
  output logic                       cmd_error
);
  localparam int NBYTES = (SAMPLE_W <= 8) ? 1 : 2;
  localparam int PAD_W  = NBYTES * 8;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

  state_t                           state;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  peak;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  snap;
  logic [CH_W-1:0]                  ch_idx;
  logic                             byte_idx;
  logic                             all_mode;
  logic [7:0]                       csum;

  logic                             idle, xfer;
  logic                             is_ch, is_all, is_clr;
  logic                             accept_rpt, accept_clr;
  logic [7:0]                       ch_off;
  logic [CH_W-1:0]                  start_ch;
  logic [NUM_CH-1:0]                rpt_mask, clr_mask;
  logic [SAMPLE_W-1:0]              cur_snap;
  logic [PAD_W-1:0]                 padded;
  logic [7:0]                       first_byte, last_byte;

  assign idle   = (state == IDLE);
  assign xfer   = tx_valid && tx_ready;
  assign ch_off = cmd_byte - 8'h31;
  assign is_ch  = (cmd_byte >= 8'h31) && (cmd_byte <= (8'h30 + 8'(NUM_CH)));
  assign is_all = (cmd_byte == 8'h2A);
  assign is_clr = (cmd_byte == 8'h52);

  assign accept_rpt = cmd_valid && idle && (is_ch || is_all);
  assign accept_clr = cmd_valid && idle && is_clr;
  assign start_ch   = is_all ? '0 : CH_W'(ch_off);

  always_comb begin
    rpt_mask = '0;
    for (int i = 0; i < NUM_CH; i++)
      rpt_mask[i] = accept_rpt && (is_all || (ch_off == 8'(i)));
  end
  assign clr_mask = rpt_mask | {NUM_CH{accept_clr}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    adc_peak_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .clk          (clk),
      .reset        (reset),
      .sample       (sample_data[i*SAMPLE_W +: SAMPLE_W]),
      .sample_valid (sample_valid[i]),
      .clear        (clr_mask[i]),
      .peak         (peak[i])
    );
  end

  // Snapshot is taken on the same edge that clears the live peak.
  always_ff @(posedge clk) begin
    if (reset)
      snap <= '0;
    else
      for (int i = 0; i < NUM_CH; i++)
        if (rpt_mask[i]) snap[i] <= peak[i];
  end

  assign cur_snap   = snap[ch_idx];
  assign padded     = PAD_W'(cur_snap);
  assign first_byte = padded[PAD_W-1 -: 8];
  assign last_byte  = padded[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_byte     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      cmd_dropped <= 1'b0;
      cmd_error   <= 1'b0;
      ch_idx      <= '0;
      byte_idx    <= 1'b0;
      all_mode    <= 1'b0;
      csum        <= '0;
    end else begin
      cmd_dropped <= cmd_valid && !idle;
      cmd_error   <= cmd_valid && idle && !(is_ch || is_all || is_clr);
      case (state)
        IDLE: if (accept_rpt) begin
          state    <= HDR;
          ch_idx   <= start_ch;
          all_mode <= is_all;
          tx_byte  <= 8'h41 + 8'(start_ch);
          tx_valid <= 1'b1;
          busy     <= 1'b1;
        end
        HDR: if (xfer) begin
          state    <= DATA;
          byte_idx <= 1'b0;
          csum     <= tx_byte;
          tx_byte  <= first_byte;
        end
        DATA: if (xfer) begin
          csum <= csum ^ tx_byte;
          if (byte_idx == 1'(NBYTES-1)) begin
            state   <= CSUM;
            tx_byte <= csum ^ tx_byte;
          end else begin
            byte_idx <= 1'b1;
            tx_byte  <= last_byte;
          end
        end
        CSUM: if (xfer) begin
          if (all_mode && (ch_idx != CH_W'(NUM_CH-1))) begin
            state   <= HDR;
            ch_idx  <= ch_idx + 1'b1;
            tx_byte <= 8'h41 + 8'(ch_idx) + 8'd1;
          end else begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/adc_peak_reporter.md
# adc_peak_reporter

Parametrised per-channel peak-hold and report packetiser between the SPI ADC front ends and the UART byte transmitter. It generalises the fixed 4-channel max-value cache plus reply logic to NUM_CH channels of SAMPLE_W bits. Each channel tracks the largest sample seen since its last report. An ASCII command byte from the UART receiver selects one channel, all channels, or a peak clear. Replies are framed, checksummed byte packets sent over a valid/ready handshake to the UART TX.

## Interface
- NUM_CH, 4: channel count, legal 1..9.
- SAMPLE_W, 10: sample width in bits, legal 1..16. NBYTES = 1 if SAMPLE_W<=8, else 2.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- sample_data  in  NUM_CH*SAMPLE_W  packed unsigned samples; channel i at [i*SAMPLE_W +: SAMPLE_W].
- sample_valid  in  NUM_CH  one-cycle strobe per channel (ADC data-ready).
- cmd_byte  in  8  received UART byte.
- cmd_valid  in  1  one-cycle strobe with cmd_byte.
- tx_byte  out  8  byte to transmit.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART TX can accept a byte.
- busy  out  1  a report is in progress.
- cmd_dropped  out  1  one-cycle pulse: a command arrived while busy.
- cmd_error  out  1  one-cycle pulse: an unrecognised command arrived while idle.

## Operation
- Peak hold: on sample_valid[i], peak[i] <= max(peak[i], sample_i). The comparison is unsigned. Peaks saturate naturally at 2^SAMPLE_W-1.
- Commands are decoded only when cmd_valid=1 and the FSM is in IDLE:
  - 0x31..0x30+NUM_CH ('1'..): report channel cmd_byte-0x31.
  - 0x2A ('*'): report all channels, ascending order.
  - 0x52 ('R'): clear all peaks to 0, send nothing.
  - Any other byte: cmd_error pulse, no other effect.
- cmd_valid while busy: the command is ignored and cmd_dropped pulses.
- Snapshot: on accepting a report command, the selected peak(s) are copied to snapshot registers and the live peak(s) are cleared in the same edge. If sample_valid[i] coincides with a clear (report or 'R'), peak[i] <= sample_i, so no sample is lost.
- Packet per channel, in order:
  - header = 0x41+i ('A'..).
  - Data bytes, MSB first, zero-padded to NBYTES*8 bits.
  - Checksum = XOR of the header and all data bytes.
- Example: SAMPLE_W=10, ch0 peak 0x2C5 -> 0x41, 0x02, 0xC5, 0x86.
- FSM states:
  - IDLE: on an accepted report command, go to HDR.
  - HDR: on transfer, go to DATA.
  - DATA: after NBYTES transfers, go to CSUM.
  - CSUM: on transfer, go to HDR of the next channel if in all-mode and channels remain, else IDLE.
- 'R' does not leave IDLE.

## Timing
- Reset values: tx_byte=0, tx_valid=0, busy=0, cmd_dropped=0, cmd_error=0, all peaks and snapshots 0, FSM in IDLE.
- Reset mid-packet abandons the packet: tx_valid=0 on the next edge and no partial resume.
- Command accepted at edge t: tx_valid=1, busy=1 and the header appear after edge t (registered, latency 1).
- Handshake:
  - A transfer occurs on an edge where tx_valid=1 and tx_ready=1.
  - tx_byte stays stable and tx_valid stays high until the transfer.
  - The next byte is presented in the cycle after the transfer. tx_valid stays high back-to-back across bytes and across channels in all-mode, with no idle gap.
- After the final checksum transfer, tx_valid=0 and busy=0 on the following cycle. A cmd_valid in the same cycle as the final transfer is dropped. A cmd_valid one cycle later is accepted.
- cmd_dropped and cmd_error are registered, asserted the cycle after the offending cmd_valid.
- Peak updates continue every cycle, including during a report. Reports carry snapshot values, not live values.
- Report length: (2+NBYTES) bytes per channel; all-mode sends NUM_CH*(2+NBYTES) bytes.

## Test plan
- Defaults, tx_ready=1. Samples on ch1: 0x100, 0x3FF, 0x050, then cmd '2' (0x32) -> exactly the bytes 0x42, 0x03, 0xFF, 0xBE. Cmd '2' again -> 0x42, 0x00, 0x00, 0x42 (peak cleared).
- Peaks ch0..3 = 0x001, 0x080, 0x200, 0x3FF, cmd '*' with tx_ready toggling 1-0-0-1 -> 16 bytes in channel order with correct checksums. tx_byte is stable whenever tx_valid=1 and tx_ready=0, and busy stays high throughout.
- During a report, cmd '1' -> cmd_dropped pulse, packet unaffected. Cmd 0x5A while idle -> cmd_error pulse, no tx_valid.
- Same cycle: cmd '1' accepted and sample_valid[0] with 0x123, prior peak 0x300 -> report carries 0x300 and the live peak becomes 0x123. Then 'R' with a coincident ch0 sample 0x010 -> peak 0x010.
- Assert reset during the data byte of a report -> tx_valid=0 and busy=0 next cycle. A later cmd '1' reports peak 0x000.
- NUM_CH=2, SAMPLE_W=8, peak 0xA5 on ch1, cmd '2' -> 0x42, 0xA5, 0xE7. Cmd '3' -> cmd_error.
